// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave device: the FSM state encoding, the
// default frame length and the synchronizer depth used on every SPI input.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int OUT_BITS_DEFAULT = 16;
  localparam int SYNC_STAGES      = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Brings one asynchronous SPI line into the system clock domain through a
// SYNC_STAGES-deep flop chain, then registers the synced value once more to
// produce single-cycle rise/fall pulses.
//
// Ports
//   i_clk    in   system clock
//   i_rst_n  in   asynchronous active-low reset
//   i_async  in   asynchronous input line
//   o_sync   out  synchronized level
//   o_rise   out  one-cycle pulse on synced 0->1
//   o_fall   out  one-cycle pulse on synced 1->0
// Parameter RESET_VAL is the idle level of the line, loaded on reset so that
// no spurious edge is reported while the line sits at its idle level.
// -----------------------------------------------------------------------------
module spi_sync
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;

  // NOTE: flops are written with non-blocking assignments so every stage
  // samples the previous stage's old value; blocking here would collapse the
  // chain into a single flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= {SYNC_STAGES{RESET_VAL}};
      r_prev  <= RESET_VAL;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
      r_prev  <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];
  assign o_rise =  o_sync & ~r_prev;
  assign o_fall = ~o_sync &  r_prev;

endmodule

// File: rtl/spi_slave_device.sv
// -----------------------------------------------------------------------------
// spi_slave_device
// SPI mode-0, MSB-first slave running entirely in the SYS_CLK domain. SCK,
// CSbar and MOSI are oversampled through spi_sync; SCK must be at most
// SYS_CLK/8. On each frame one word is pulled from a transmit FIFO
// (DATA_MISO/TX_VALID/TX_RD) and one received word is published on DATA_MOSI.
//
// Ports
//   SYS_CLK    in   system clock, rising edge
//   RSTbar     in   asynchronous active-low reset
//   SCK        in   SPI clock from master (asynchronous)
//   CSbar      in   chip select, active-low (asynchronous)
//   MOSI       in   serial data from master (asynchronous)
//   MISO       out  serial data to master
//   DATA_MISO  in   word to transmit (FIFO dout)
//   TX_VALID   in   DATA_MISO valid (FIFO not empty)
//   TX_RD      out  one-cycle pulse consuming DATA_MISO
//   DATA_MOSI  out  last complete received word
//   FIN        out  one-cycle pulse, full frame received
//   BUSY       out  high while a frame is in progress
//   UNDERRUN   out  one-cycle pulse, frame started with TX_VALID low
//   ERR_SHORT  out  sticky, a frame ended before outBits bits; reset clears
//
// Build option
//   SPI_SLAVE_MISO_TRISTATE_EN  defined: MISO is high-Z while deselected;
//                               undefined: MISO drives 0 while deselected.
// -----------------------------------------------------------------------------
module spi_slave_device
  import spi_pkg::*;
#(
  parameter int outBits = OUT_BITS_DEFAULT
) (
  input  logic               SYS_CLK,
  input  logic               RSTbar,
  input  logic               SCK,
  input  logic               CSbar,
  input  logic               MOSI,
  output logic               MISO,
  input  logic [outBits-1:0] DATA_MISO,
  input  logic               TX_VALID,
  output logic               TX_RD,
  output logic [outBits-1:0] DATA_MOSI,
  output logic               FIN,
  output logic               BUSY,
  output logic               UNDERRUN,
  output logic               ERR_SHORT
);

  localparam int CNT_W    = $clog2(outBits + 1);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]    FULL_CNT    = CNT_W'(outBits);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES);

  logic w_sck_sync, w_sck_rise, w_sck_fall;
  logic w_cs_sync,  w_cs_rise,  w_cs_fall;
  logic w_mosi_sync, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_sync #(.RESET_VAL(1'b0)) u_sync_sck (
    .i_clk   (SYS_CLK),
    .i_rst_n (RSTbar),
    .i_async (SCK),
    .o_sync  (w_sck_sync),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .i_clk   (SYS_CLK),
    .i_rst_n (RSTbar),
    .i_async (CSbar),
    .o_sync  (w_cs_sync),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk   (SYS_CLK),
    .i_rst_n (RSTbar),
    .i_async (MOSI),
    .o_sync  (w_mosi_sync),
    .o_rise  (w_unused_mosi_rise),
    .o_fall  (w_unused_mosi_fall)
  );

  // MOSI level is sampled on SCK edges; its own edge pulses are not needed.
  logic w_unused_sck_level;
  assign w_unused_sck_level = w_sck_sync;

  spi_state_t           r_state;
  logic [outBits-1:0]   r_tx_shift;
  logic [outBits-1:0]   r_rx_shift;
  logic [CNT_W-1:0]     r_count;
  logic [outBits-1:0]   r_data_mosi;
  logic                 r_fin;
  logic                 r_tx_rd;
  logic                 r_underrun;
  logic                 r_err_short;
  logic [SETTLE_W-1:0]  r_settle;
  logic                 r_armed;

  // The CSbar synchronizer resets to "deselected", so if CSbar is already low
  // when reset releases, the chain flushes to 0 and reports a fall that is not
  // a real frame start. r_armed only sets once the chain holds real samples
  // and shows CSbar high, which suppresses that artefact.
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      r_state     <= IDLE;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_count     <= '0;
      r_data_mosi <= '0;
      r_fin       <= 1'b0;
      r_tx_rd     <= 1'b0;
      r_underrun  <= 1'b0;
      r_err_short <= 1'b0;
      r_settle    <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_fin      <= 1'b0;
      r_tx_rd    <= 1'b0;
      r_underrun <= 1'b0;

      if (r_settle != SETTLE_DONE) begin
        r_settle <= r_settle + 1'b1;
      end else if (w_cs_sync) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_cs_fall && r_armed) begin
            r_tx_shift <= TX_VALID ? DATA_MISO : '0;
            r_tx_rd    <= TX_VALID;
            r_underrun <= ~TX_VALID;
            r_count    <= '0;
            r_state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (r_count == FULL_CNT) begin
            r_data_mosi <= r_rx_shift;
            r_fin       <= 1'b1;
            // A deselect landing in this very cycle would be lost in WAIT_CS.
            r_state     <= w_cs_rise ? IDLE : WAIT_CS;
          end else if (w_cs_rise) begin
            r_err_short <= 1'b1;
            r_state     <= IDLE;
          end else begin
            if (w_sck_rise) begin
              r_rx_shift <= {r_rx_shift[outBits-2:0], w_mosi_sync};
              r_count    <= r_count + 1'b1;
            end
            if (w_sck_fall) begin
              r_tx_shift <= {r_tx_shift[outBits-2:0], 1'b0};
            end
          end
        end

        WAIT_CS: begin
          if (w_cs_rise) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign TX_RD     = r_tx_rd;
  assign FIN       = r_fin;
  assign UNDERRUN  = r_underrun;
  assign ERR_SHORT = r_err_short;
  assign DATA_MOSI = r_data_mosi;
  assign BUSY      = (r_state != IDLE);

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign MISO = w_cs_sync ? 1'bz : r_tx_shift[outBits-1];
`else
  assign MISO = ~w_cs_sync & r_tx_shift[outBits-1];
`endif

endmodule

// File: tb/tb_spi_slave_device.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_device
// Drives spi_slave_device as an SPI mode-0 master at SYS_CLK/8 and compares
// every frame against a frame-level model: what the master should see on
// MISO, what DATA_MOSI should hold, and how many FIN/TX_RD/UNDERRUN pulses the
// frame should produce.
// -----------------------------------------------------------------------------
module tb_spi_slave_device;

  localparam int W      = 16;
  localparam int T_HALF = 5;    // SYS_CLK half period
  localparam int T_SCK  = 40;   // SCK half period: SCK = SYS_CLK/8

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  logic         SYS_CLK = 1'b0;
  logic         RSTbar;
  logic         SCK;
  logic         CSbar;
  logic         MOSI;
  logic         MISO;
  logic [W-1:0] DATA_MISO;
  logic         TX_VALID;
  logic         TX_RD;
  logic [W-1:0] DATA_MOSI;
  logic         FIN;
  logic         BUSY;
  logic         UNDERRUN;
  logic         ERR_SHORT;

  spi_slave_device #(.outBits(W)) dut (
    .SYS_CLK   (SYS_CLK),
    .RSTbar    (RSTbar),
    .SCK       (SCK),
    .CSbar     (CSbar),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .DATA_MISO (DATA_MISO),
    .TX_VALID  (TX_VALID),
    .TX_RD     (TX_RD),
    .DATA_MOSI (DATA_MOSI),
    .FIN       (FIN),
    .BUSY      (BUSY),
    .UNDERRUN  (UNDERRUN),
    .ERR_SHORT (ERR_SHORT)
  );

  always #T_HALF SYS_CLK = ~SYS_CLK;

  // Pulse counters: every SYS_CLK cycle an output is high counts once, so a
  // pulse that is wider than one cycle shows up as an extra count.
  int fin_cnt = 0;
  int rd_cnt  = 0;
  int ur_cnt  = 0;
  always @(posedge SYS_CLK) begin
    if (FIN === 1'b1)      fin_cnt <= fin_cnt + 1;
    if (TX_RD === 1'b1)    rd_cnt  <= rd_cnt + 1;
    if (UNDERRUN === 1'b1) ur_cnt  <= ur_cnt + 1;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model state carried across frames.
  logic [W-1:0] model_data;
  logic         model_err;

  // One master frame of n SCK cycles. Bit i sent is mosi_w[31-i]; the MISO
  // level seen just before SCK rise i lands in miso_w[31-i].
  task automatic spi_frame(input logic [31:0] mosi_w, input int n,
                           output logic [31:0] miso_w, output logic busy_mid);
    miso_w = '0;
    CSbar  = 1'b0;
    #200;
    busy_mid = BUSY;
    for (int i = 0; i < n; i++) begin
      MOSI = mosi_w[31-i];
      #T_SCK;
      miso_w[31-i] = MISO;
      SCK = 1'b1;
      #T_SCK;
      SCK = 1'b0;
    end
    #T_SCK;
    CSbar = 1'b1;
    #200;
  endtask

  task automatic run_frame(input string tag, input logic [W-1:0] tx,
                           input logic valid, input logic [31:0] mosi_w, input int n);
    logic [31:0] miso_w, mask, exp_miso;
    logic        busy_mid;
    int          f0, r0, u0, k;
    DATA_MISO = tx;
    TX_VALID  = valid;
    f0 = fin_cnt; r0 = rd_cnt; u0 = ur_cnt;
    spi_frame(mosi_w, n, miso_w, busy_mid);
    TX_VALID = 1'b0;

    k        = (n < W) ? n : W;
    mask     = ~(32'hFFFF_FFFF >> k);
    exp_miso = valid ? {tx, 16'h0000} : 32'h0;
    if (n >= W) model_data = mosi_w[31:16];
    else        model_err  = 1'b1;

    check({tag, ".miso"},     miso_w & mask, exp_miso & mask);
    check({tag, ".data"},     {16'h0, DATA_MOSI}, {16'h0, model_data});
    check({tag, ".fin"},      fin_cnt - f0, (n >= W) ? 1 : 0);
    check({tag, ".tx_rd"},    rd_cnt - r0, valid ? 1 : 0);
    check({tag, ".underrun"}, ur_cnt - u0, valid ? 0 : 1);
    check({tag, ".err"},      {31'h0, ERR_SHORT}, {31'h0, model_err});
    check({tag, ".busy_mid"}, {31'h0, busy_mid}, 32'h1);
    check({tag, ".busy_end"}, {31'h0, BUSY}, 32'h0);
  endtask

  initial begin
    int f0, r0, u0;
    RSTbar = 1'b0; SCK = 1'b0; CSbar = 1'b1; MOSI = 1'b0;
    DATA_MISO = '0; TX_VALID = 1'b0;
    model_data = '0; model_err = 1'b0;
    // Offset stimulus from the clock edges.
    #52;
    check("rst.busy", {31'h0, BUSY}, 32'h0);
    check("rst.data", {16'h0, DATA_MOSI}, 32'h0);
    check("rst.err",  {31'h0, ERR_SHORT}, 32'h0);
    check("rst.fin",  {31'h0, FIN}, 32'h0);
    check("rst.tx_rd", {31'h0, TX_RD}, 32'h0);
    RSTbar = 1'b1;
    #200;
    check("idle.miso", {31'h0, MISO}, {31'h0, MISO_IDLE});

    run_frame("basic",    16'hA5C3, 1'b1, {16'h1234, 16'h0}, 16);
    run_frame("underrun", 16'hFFFF, 1'b0, {16'hBEEF, 16'h0}, 16);
    run_frame("short",    16'h5A5A, 1'b1, {16'hC0DE, 16'h0}, 9);
    run_frame("long",     16'h0F0F, 1'b1, 32'h8765_4321,     20);
    check("deselect.miso", {31'h0, MISO}, {31'h0, MISO_IDLE});

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] tx;
      logic         v;
      int           n;
      tx = W'($urandom);
      v  = ($urandom_range(3, 0) != 0);
      n  = $urandom_range(20, 8);
      run_frame($sformatf("rnd%0d", i), tx, v, $urandom, n);
    end

    // Reset in the middle of a frame with CSbar held low afterwards.
    DATA_MISO = 16'h3C3C; TX_VALID = 1'b1;
    CSbar = 1'b0;
    #200;
    for (int i = 0; i < 5; i++) begin
      SCK = 1'b1; #T_SCK; SCK = 1'b0; #T_SCK;
    end
    RSTbar = 1'b0;
    #30;
    check("midrst.busy", {31'h0, BUSY}, 32'h0);
    check("midrst.data", {16'h0, DATA_MOSI}, 32'h0);
    check("midrst.err",  {31'h0, ERR_SHORT}, 32'h0);
    model_data = '0; model_err = 1'b0;
    RSTbar = 1'b1;
    f0 = fin_cnt; r0 = rd_cnt; u0 = ur_cnt;
    #200;
    for (int i = 0; i < 16; i++) begin
      MOSI = i[0]; #T_SCK; SCK = 1'b1; #T_SCK; SCK = 1'b0;
    end
    #T_SCK;
    check("held.busy",     {31'h0, BUSY}, 32'h0);
    check("held.fin",      fin_cnt - f0, 0);
    check("held.tx_rd",    rd_cnt - r0, 0);
    check("held.underrun", ur_cnt - u0, 0);
    CSbar = 1'b1;
    TX_VALID = 1'b0;
    #200;
    run_frame("after_rst", 16'h9669, 1'b1, {16'h4B2D, 16'h0}, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
